// File: rtl/beta_mem_sched_pkg.sv
// -----------------------------------------------------------------------------
// beta_mem_sched_pkg
// Shared constants and helpers for the beta-memory sweep scheduler.
//   P, Q, N, LMAX  : default geometry (values per block, bits per value,
//                    code length, highest stored beta layer)
//   CNT_W, LAYER_W : widths of the beat counters and layer fields
//   chan_state_t   : per-channel sequencer state
//   beat_count     : max(1, 2^l / div), the number of beats to sweep layer l
//   w_beats/r_beats: write (div = 2P) and read (div = P) beat counts
// -----------------------------------------------------------------------------
package beta_mem_sched_pkg;

    localparam int P       = 16;
    localparam int Q       = 6;
    localparam int N       = 1024;
    localparam int LMAX    = 8;
    localparam int CNT_W   = 6;
    localparam int LAYER_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } chan_state_t;

    // Layers outside the legal range never reach the sweep logic, so a
    // wrapped shift for large l only ever yields the harmless minimum of 1.
    function automatic int beat_count(input logic [LAYER_W-1:0] l, input int div);
        int v;
        v = (1 << l) / div;
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int w_beats(input logic [LAYER_W-1:0] l);
        return beat_count(l, 2 * P);
    endfunction

    function automatic int r_beats(input logic [LAYER_W-1:0] l);
        return beat_count(l, P);
    endfunction

endpackage

// File: rtl/beta_mem_sched_chan.sv
// -----------------------------------------------------------------------------
// beta_chan_seq
// One sweep channel: accepts a layer command, then drives en/cnt/layer for
// beat_count(layer, DIV) consecutive cycles and pulses done on the last beat.
//   clk, rst   : clock, synchronous active-high reset
//   cmd_valid  : command request
//   cmd_layer  : requested layer
//   cmd_block  : external hold-off (read-after-write hazard)
//   cmd_ready  : command accepted this cycle when cmd_valid is high
//   en         : beat enable, high every cycle of a sweep
//   layer      : latched layer of the running sweep (0 when idle)
//   cnt        : beat index 0..beats-1 (0 when idle)
//   done       : high on the final beat
//   err        : one-cycle pulse after an illegal layer was accepted
// -----------------------------------------------------------------------------
module beta_chan_seq #(
    parameter int DIV  = 32,
    parameter int LMAX = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cmd_valid,
    input  logic [beta_mem_sched_pkg::LAYER_W-1:0] cmd_layer,
    input  logic                                   cmd_block,
    output logic                                   cmd_ready,
    output logic                                   en,
    output logic [beta_mem_sched_pkg::LAYER_W-1:0] layer,
    output logic [beta_mem_sched_pkg::CNT_W-1:0]   cnt,
    output logic                                   done,
    output logic                                   err
);
    import beta_mem_sched_pkg::*;

    chan_state_t      state;
    logic             live;       // low during and for one cycle after reset
    logic [CNT_W-1:0] last_cnt;   // beats-1 of the running sweep
    logic [CNT_W-1:0] first_last; // beats-1 of the incoming command
    logic             legal;
    logic             hs;

    assign legal      = (cmd_layer != '0) && (int'(cmd_layer) <= LMAX);
    assign first_last = CNT_W'(beat_count(cmd_layer, DIV) - 1);

    // done marks the final beat, so a new command can be taken in that cycle
    // and the next sweep follows without an idle cycle.
    assign cmd_ready = live && ((state == IDLE) || done) && !cmd_block;
    assign hs        = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            live     <= 1'b0;
            en       <= 1'b0;
            layer    <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            last_cnt <= '0;
        end else begin
            live <= 1'b1;
            err  <= hs && !legal;
            if (hs && legal) begin
                state    <= BUSY;
                en       <= 1'b1;
                layer    <= cmd_layer;
                cnt      <= '0;
                last_cnt <= first_last;
                done     <= (first_last == '0);
            end else if ((state == BUSY) && !done) begin
                cnt  <= cnt + 1'b1;
                done <= (CNT_W'(cnt + 1'b1) == last_cnt);
            end else begin
                state    <= IDLE;
                en       <= 1'b0;
                layer    <= '0;
                cnt      <= '0;
                done     <= 1'b0;
                last_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/beta_mem_sched.sv
// -----------------------------------------------------------------------------
// beta_mem_sched
// Schedules write and read sweeps of the beta memory. Two beta_chan_seq
// instances run the channels; this level adds the read-after-write hazard,
// illegal-layer error reporting and the rd_vld alignment register.
//   clk, rst                         : clock, synchronous active-high reset
//   wcmd_valid/wcmd_layer/wcmd_ready : write-sweep command handshake
//   rcmd_valid/rcmd_layer/rcmd_ready : read-sweep command handshake
//   w_en, layer_w, cnta              : beta-memory write controls
//   r_en, layer_r, cntb              : beta-memory read controls
//   rd_vld                           : read data valid (r_en one cycle late)
//   wr_done, rd_done                 : pulse on the last beat of a sweep
//   cmd_err                          : pulse after an illegal layer is accepted
// -----------------------------------------------------------------------------
module beta_mem_sched #(
    parameter int P    = 16,
    parameter int Q    = 6,
    parameter int N    = 1024,
    parameter int LMAX = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wcmd_valid,
    input  logic [beta_mem_sched_pkg::LAYER_W-1:0] wcmd_layer,
    output logic                                   wcmd_ready,
    input  logic                                   rcmd_valid,
    input  logic [beta_mem_sched_pkg::LAYER_W-1:0] rcmd_layer,
    output logic                                   rcmd_ready,
    output logic                                   w_en,
    output logic [beta_mem_sched_pkg::LAYER_W-1:0] layer_w,
    output logic [beta_mem_sched_pkg::CNT_W-1:0]   cnta,
    output logic                                   r_en,
    output logic [beta_mem_sched_pkg::LAYER_W-1:0] layer_r,
    output logic [beta_mem_sched_pkg::CNT_W-1:0]   cntb,
    output logic                                   rd_vld,
    output logic                                   wr_done,
    output logic                                   rd_done,
    output logic                                   cmd_err
);
    import beta_mem_sched_pkg::*;

    if ((Q < 1) || (N < 2 * P) || (LMAX > $clog2(N)) ||
        (((1 << LMAX) / P) > (1 << CNT_W))) begin : g_param_check
        $error("beta_mem_sched: inconsistent P/Q/N/LMAX parameters");
    end

    logic w_err;
    logic r_err;
    logic w_take;
    logic hazard;

    // A write that is being accepted this cycle and will actually sweep.
    assign w_take = wcmd_valid && wcmd_ready && (wcmd_layer != '0) &&
                    (int'(wcmd_layer) <= LMAX);

    // Hold reads of a layer that is still being written. The running write
    // releases the hold on its final beat; a write accepted in the same cycle
    // to the same layer keeps it held.
    assign hazard = (w_en && !wr_done && (layer_w == rcmd_layer)) ||
                    (w_take && (wcmd_layer == rcmd_layer));

    beta_chan_seq #(
        .DIV  (2 * P),
        .LMAX (LMAX)
    ) u_wr (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (wcmd_valid),
        .cmd_layer (wcmd_layer),
        .cmd_block (1'b0),
        .cmd_ready (wcmd_ready),
        .en        (w_en),
        .layer     (layer_w),
        .cnt       (cnta),
        .done      (wr_done),
        .err       (w_err)
    );

    beta_chan_seq #(
        .DIV  (P),
        .LMAX (LMAX)
    ) u_rd (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (rcmd_valid),
        .cmd_layer (rcmd_layer),
        .cmd_block (hazard),
        .cmd_ready (rcmd_ready),
        .en        (r_en),
        .layer     (layer_r),
        .cnt       (cntb),
        .done      (rd_done),
        .err       (r_err)
    );

    assign cmd_err = w_err || r_err;

    // Memory read data is registered, so its valid trails r_en by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= r_en;
        end
    end

endmodule

// File: tb/tb_beta_mem_sched.sv
module tb_beta_mem_sched;

    localparam int TP    = 16;
    localparam int TLMAX = 8;

    logic       clk;
    logic       rst;
    logic       wcmd_valid;
    logic [4:0] wcmd_layer;
    logic       wcmd_ready;
    logic       rcmd_valid;
    logic [4:0] rcmd_layer;
    logic       rcmd_ready;
    logic       w_en;
    logic [4:0] layer_w;
    logic [5:0] cnta;
    logic       r_en;
    logic [4:0] layer_r;
    logic [5:0] cntb;
    logic       rd_vld;
    logic       wr_done;
    logic       rd_done;
    logic       cmd_err;

    beta_mem_sched #(.P(TP), .Q(6), .N(1024), .LMAX(TLMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .wcmd_valid (wcmd_valid),
        .wcmd_layer (wcmd_layer),
        .wcmd_ready (wcmd_ready),
        .rcmd_valid (rcmd_valid),
        .rcmd_layer (rcmd_layer),
        .rcmd_ready (rcmd_ready),
        .w_en       (w_en),
        .layer_w    (layer_w),
        .cnta       (cnta),
        .r_en       (r_en),
        .layer_r    (layer_r),
        .cntb       (cntb),
        .rd_vld     (rd_vld),
        .wr_done    (wr_done),
        .rd_done    (rd_done),
        .cmd_err    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int layer;
        int cnt;
        bit last;
    } beat_t;

    // Beats still to come after the one currently on the outputs.
    beat_t w_q[$];
    beat_t r_q[$];
    bit    live;
    bit    err_exp;
    int    total;
    int    bad;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input int l);
        return (l >= 1) && (l <= TLMAX);
    endfunction

    function automatic int n_beats(input int l, input int div);
        int v;
        v = (2 ** l) / div;
        return (v < 1) ? 1 : v;
    endfunction

    function automatic void push_sweep(input bit is_wr, input int l);
        int nb;
        beat_t b;
        nb = n_beats(l, is_wr ? 2 * TP : TP);
        for (int i = 0; i < nb; i++) begin
            b.layer = l;
            b.cnt   = i;
            b.last  = (i == nb - 1);
            if (is_wr) w_q.push_back(b);
            else       r_q.push_back(b);
        end
    endfunction

    // One clock cycle of stimulus: drive, check ready against the model,
    // record expected beats for whatever the model says gets accepted.
    task automatic step(input bit wv, input int wl, input bit rv, input int rl,
                        input bit r, output bit wa, output bit ra);
        bit exp_wr, exp_rr, blocked, w_sweep;
        @(negedge clk);
        rst        = r;
        wcmd_valid = wv && !r;
        wcmd_layer = 5'(wl);
        rcmd_valid = rv && !r;
        rcmd_layer = 5'(rl);
        #1;
        exp_wr  = live && (w_q.size() == 0);
        wa      = wcmd_valid && exp_wr;
        w_sweep = wa && is_legal(wl);
        blocked = ((w_q.size() > 0) && (w_q[0].layer == rl)) || (w_sweep && (wl == rl));
        exp_rr  = live && (r_q.size() == 0) && !blocked;
        ra      = rcmd_valid && exp_rr;
        chk("wcmd_ready", int'(wcmd_ready), int'(exp_wr));
        chk("rcmd_ready", int'(rcmd_ready), int'(exp_rr));
        if (r) begin
            w_q.delete();
            r_q.delete();
            err_exp = 1'b0;
        end else begin
            if (w_sweep) push_sweep(1'b1, wl);
            if (ra && is_legal(rl)) push_sweep(1'b0, rl);
            err_exp = (wa && !is_legal(wl)) || (ra && !is_legal(rl));
        end
        live = !r;
    endtask

    // Monitor: pops one expected beat per channel per cycle.
    initial begin : monitor
        bit    rs;
        bit    prev_ren;
        bit    exp_ren;
        beat_t e;
        prev_ren = 1'b0;
        forever begin
            @(posedge clk);
            rs = rst;
            #1;
            if (w_q.size() > 0) begin
                e = w_q.pop_front();
                chk("w_en", int'(w_en), 1);
                chk("layer_w", int'(layer_w), e.layer);
                chk("cnta", int'(cnta), e.cnt);
                chk("wr_done", int'(wr_done), int'(e.last));
            end else begin
                chk("w_en_idle", int'(w_en), 0);
                chk("layer_w_idle", int'(layer_w), 0);
                chk("cnta_idle", int'(cnta), 0);
                chk("wr_done_idle", int'(wr_done), 0);
            end
            exp_ren = (r_q.size() > 0);
            if (exp_ren) begin
                e = r_q.pop_front();
                chk("r_en", int'(r_en), 1);
                chk("layer_r", int'(layer_r), e.layer);
                chk("cntb", int'(cntb), e.cnt);
                chk("rd_done", int'(rd_done), int'(e.last));
            end else begin
                chk("r_en_idle", int'(r_en), 0);
                chk("layer_r_idle", int'(layer_r), 0);
                chk("cntb_idle", int'(cntb), 0);
                chk("rd_done_idle", int'(rd_done), 0);
            end
            chk("rd_vld", int'(rd_vld), rs ? 0 : int'(prev_ren));
            prev_ren = exp_ren;
            chk("cmd_err", int'(cmd_err), rs ? 0 : int'(err_exp));
        end
    end

    initial begin : driver
        bit wa, ra;
        int last_wl;
        total      = 0;
        bad        = 0;
        live       = 1'b0;
        err_exp    = 1'b0;
        rst        = 1'b1;
        wcmd_valid = 1'b0;
        wcmd_layer = '0;
        rcmd_valid = 1'b0;
        rcmd_layer = '0;

        // reset, then release: ready must stay low one more cycle
        repeat (3) step(0, 0, 0, 0, 1, wa, ra);
        repeat (3) step(0, 0, 0, 0, 0, wa, ra);

        // write layer 8: 8 beats
        step(1, 8, 0, 0, 0, wa, ra);
        repeat (10) step(0, 0, 0, 0, 0, wa, ra);

        // read layer 5: 2 beats
        step(0, 0, 1, 5, 0, wa, ra);
        repeat (5) step(0, 0, 0, 0, 0, wa, ra);

        // write 7 and read 7 together: read held until the final write beat
        step(1, 7, 1, 7, 0, wa, ra);
        for (int i = 0; i < 20 && !ra; i++) step(0, 0, 1, 7, 0, wa, ra);
        if (!ra) chk("raw_accept_timeout", 0, 1);
        repeat (12) step(0, 0, 0, 0, 0, wa, ra);

        // concurrent write 6 / read 3
        step(1, 6, 1, 3, 0, wa, ra);
        repeat (4) step(0, 0, 0, 0, 0, wa, ra);

        // back-to-back reads of layers 1 then 2
        step(0, 0, 1, 1, 0, wa, ra);
        step(0, 0, 1, 2, 0, wa, ra);
        repeat (4) step(0, 0, 0, 0, 0, wa, ra);

        // illegal layers 9 (write) and 0 (read)
        step(1, 9, 0, 0, 0, wa, ra);
        repeat (2) step(0, 0, 0, 0, 0, wa, ra);
        step(0, 0, 1, 0, 0, wa, ra);
        repeat (2) step(0, 0, 0, 0, 0, wa, ra);

        // reset on the third beat of a layer-8 write
        step(1, 8, 0, 0, 0, wa, ra);
        repeat (2) step(0, 0, 0, 0, 0, wa, ra);
        step(0, 0, 0, 0, 1, wa, ra);
        repeat (10) step(0, 0, 0, 0, 0, wa, ra);

        // randomized traffic with occasional resets
        last_wl = 8;
        for (int c = 0; c < 3000; c++) begin
            int  wl, rl;
            bit  wv, rv, r;
            wv = ($urandom_range(0, 2) == 0);
            wl = $urandom_range(0, 10);
            if (wv && is_legal(wl)) last_wl = wl;
            rv = ($urandom_range(0, 2) == 0);
            rl = ($urandom_range(0, 2) == 0) ? last_wl : $urandom_range(0, 10);
            r  = ($urandom_range(0, 249) == 0);
            step(wv, wl, rv, rl, r, wa, ra);
        end
        repeat (30) step(0, 0, 0, 0, 0, wa, ra);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
